// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//   Boot loader. It receives a program image as a byte stream (valid/ready),
//   packs the bytes little-endian into DATA_W words and writes them into a
//   single-port BSRAM. It owns the BSRAM address/control mux: while booting it
//   drives the port, and after the load it passes the CPU program counter
//   through. o_boot_mode holds the CPU until the image has been written.
//
// Parameters
//   ADDR_W  BSRAM address width (largest image = 2**ADDR_W words)
//   DATA_W  BSRAM word width, must be a multiple of 8
//
// Optional feature (macro CHECKSUM_EN)
//   When defined, one extra byte follows the image. The 8-bit sum of all
//   image bytes plus that byte must be 8'h00. A mismatch parks the loader in
//   an error state with o_err=1 until i_start or reset.
//   When undefined, there are no checksum/error states and o_err is tied to 0.
//
// Ports
//   clk, rst_n      clock (shared with the BSRAM), async active-low reset
//   i_start         1-cycle reload pulse, honoured only when done/error
//   i_prog_len      image length in words, sampled after reset release / start
//   i_s_valid/i_s_data/o_s_ready   byte stream
//   i_cpu_addr      CPU program counter, routed to o_mem_ad when done
//   o_mem_ce/o_mem_wre/o_mem_ad/o_mem_din   BSRAM port
//   o_boot_mode     1 while loading or in error
//   o_words_done    number of words written
//   o_err           checksum error
// ---------------------------------------------------------------------------
module prog_loader #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_prog_len,
    input  logic              i_s_valid,
    input  logic [7:0]        i_s_data,
    output logic              o_s_ready,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    output logic              o_mem_ce,
    output logic              o_mem_wre,
    output logic [ADDR_W-1:0] o_mem_ad,
    output logic [DATA_W-1:0] o_mem_din,
    output logic              o_boot_mode,
    output logic [ADDR_W:0]   o_words_done,
    output logic              o_err
);

    localparam int unsigned BPW    = DATA_W / 8;
    localparam int unsigned BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned LEN_W  = ADDR_W + 1;

    // S_INIT samples i_prog_len one cycle after reset release or start
    typedef enum logic [2:0] {
        S_INIT,
        S_RECV,
        S_WRITE,
        S_DONE
`ifdef CHECKSUM_EN
        ,
        S_CSUM,
        S_ERR
`endif
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    w_len_nxt;
    logic [DATA_W-1:0]   r_word;
    logic [DATA_W-1:0]   w_word_nxt;
    logic [BIDX_W-1:0]   r_bidx;
    logic [BIDX_W-1:0]   w_bidx_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [LEN_W-1:0]    r_words;
    logic [LEN_W-1:0]    w_words_nxt;
    logic [ADDR_W-1:0]   r_mem_ad;
    logic [ADDR_W-1:0]   w_mem_ad_nxt;
    logic [DATA_W-1:0]   r_mem_din;
    logic [DATA_W-1:0]   w_mem_din_nxt;
    logic                r_s_ready;
    logic                w_s_ready_nxt;
    logic                r_mem_wre;
    logic                w_mem_wre_nxt;
    logic                r_boot_mode;
    logic                w_boot_nxt;
    logic                w_accept;
`ifdef CHECKSUM_EN
    logic [7:0]          r_sum;
    logic [7:0]          w_sum_nxt;
    logic                r_err;
    logic                w_err_nxt;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, datapath and next registered-output values
    always_comb begin
        w_state_nxt   = r_state;
        w_len_nxt     = r_len;
        w_word_nxt    = r_word;
        w_bidx_nxt    = r_bidx;
        w_addr_nxt    = r_addr;
        w_words_nxt   = r_words;
        w_mem_ad_nxt  = r_mem_ad;
        w_mem_din_nxt = r_mem_din;
`ifdef CHECKSUM_EN
        w_sum_nxt     = r_sum;
`endif
        w_accept      = i_s_valid && r_s_ready;

        case (r_state)
            S_INIT: begin
                w_len_nxt   = i_prog_len;
                w_state_nxt = (i_prog_len == '0) ? S_DONE : S_RECV;
            end

            S_RECV: begin
                if (w_accept) begin
                    // little-endian: byte k of the word lands in bits [8k+7:8k]
                    for (int k = 0; k < int'(BPW); k++) begin
                        if (r_bidx == BIDX_W'(k)) begin
                            w_word_nxt[8*k +: 8] = i_s_data;
                        end
                    end
`ifdef CHECKSUM_EN
                    w_sum_nxt = 8'(r_sum + i_s_data);
`endif
                    if (r_bidx == BIDX_W'(BPW - 1)) begin
                        w_bidx_nxt    = '0;
                        w_mem_din_nxt = w_word_nxt;
                        w_mem_ad_nxt  = r_addr;
                        w_state_nxt   = S_WRITE;
                    end else begin
                        w_bidx_nxt = BIDX_W'(r_bidx + 1'b1);
                    end
                end
            end

            S_WRITE: begin
                // r_addr may wrap after the last word of a full-size image,
                // but no further write follows, so address 0 is never touched
                w_addr_nxt  = ADDR_W'(r_addr + 1'b1);
                w_words_nxt = LEN_W'(r_words + 1'b1);
                if (w_words_nxt == r_len) begin
`ifdef CHECKSUM_EN
                    w_state_nxt = S_CSUM;
`else
                    w_state_nxt = S_DONE;
`endif
                end else begin
                    w_state_nxt = S_RECV;
                end
            end

`ifdef CHECKSUM_EN
            S_CSUM: begin
                if (w_accept) begin
                    w_state_nxt = (8'(r_sum + i_s_data) == 8'h00) ? S_DONE : S_ERR;
                end
            end
`endif

            S_DONE
`ifdef CHECKSUM_EN
            , S_ERR
`endif
            : begin
                // reload: counters clear immediately, length sampled in S_INIT
                if (i_start) begin
                    w_addr_nxt   = '0;
                    w_words_nxt  = '0;
                    w_bidx_nxt   = '0;
                    w_word_nxt   = '0;
                    w_mem_ad_nxt = '0;
`ifdef CHECKSUM_EN
                    w_sum_nxt    = '0;
`endif
                    w_state_nxt  = S_INIT;
                end
            end

            default: begin
                w_state_nxt = S_INIT;
            end
        endcase

        w_s_ready_nxt = (w_state_nxt == S_RECV)
`ifdef CHECKSUM_EN
                        || (w_state_nxt == S_CSUM)
`endif
                        ;
        w_mem_wre_nxt = (w_state_nxt == S_WRITE);
        w_boot_nxt    = (w_state_nxt != S_DONE);
`ifdef CHECKSUM_EN
        w_err_nxt     = (w_state_nxt == S_ERR);
`endif
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len       <= '0;
            r_word      <= '0;
            r_bidx      <= '0;
            r_addr      <= '0;
            r_words     <= '0;
            r_mem_ad    <= '0;
            r_mem_din   <= '0;
            r_s_ready   <= 1'b0;
            r_mem_wre   <= 1'b0;
            r_boot_mode <= 1'b1;
`ifdef CHECKSUM_EN
            r_sum       <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_len       <= w_len_nxt;
            r_word      <= w_word_nxt;
            r_bidx      <= w_bidx_nxt;
            r_addr      <= w_addr_nxt;
            r_words     <= w_words_nxt;
            r_mem_ad    <= w_mem_ad_nxt;
            r_mem_din   <= w_mem_din_nxt;
            r_s_ready   <= w_s_ready_nxt;
            r_mem_wre   <= w_mem_wre_nxt;
            r_boot_mode <= w_boot_nxt;
`ifdef CHECKSUM_EN
            r_sum       <= w_sum_nxt;
            r_err       <= w_err_nxt;
`endif
        end
    end

    assign o_s_ready    = r_s_ready;
    assign o_mem_ce     = 1'b1;
    assign o_mem_wre    = r_mem_wre;
    // once loaded, the CPU PC reaches the BSRAM without a register stage
    assign o_mem_ad     = (r_state == S_DONE) ? i_cpu_addr : r_mem_ad;
    assign o_mem_din    = r_mem_din;
    assign o_boot_mode  = r_boot_mode;
    assign o_words_done = r_words;
`ifdef CHECKSUM_EN
    assign o_err        = r_err;
`else
    assign o_err        = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//   Directed bench for prog_loader (ADDR_W=11, DATA_W=16). Expected BSRAM
//   writes are pushed to a queue as words are streamed in; a negedge monitor
//   records the writes the DUT actually performs, and the two are compared
//   after each image. Define CHECKSUM_EN for both bench and RTL to exercise
//   the checksum path.
// ---------------------------------------------------------------------------
module tb_prog_loader;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned BPW    = DATA_W / 8;
    localparam int unsigned ENT_W  = ADDR_W + DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_start = 1'b0;
    logic [ADDR_W:0]   i_prog_len = '0;
    logic              i_s_valid = 1'b0;
    logic [7:0]        i_s_data = '0;
    logic              o_s_ready;
    logic [ADDR_W-1:0] i_cpu_addr = '0;
    logic              o_mem_ce;
    logic              o_mem_wre;
    logic [ADDR_W-1:0] o_mem_ad;
    logic [DATA_W-1:0] o_mem_din;
    logic              o_boot_mode;
    logic [ADDR_W:0]   o_words_done;
    logic              o_err;

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_prog_len   (i_prog_len),
        .i_s_valid    (i_s_valid),
        .i_s_data     (i_s_data),
        .o_s_ready    (o_s_ready),
        .i_cpu_addr   (i_cpu_addr),
        .o_mem_ce     (o_mem_ce),
        .o_mem_wre    (o_mem_wre),
        .o_mem_ad     (o_mem_ad),
        .o_mem_din    (o_mem_din),
        .o_boot_mode  (o_boot_mode),
        .o_words_done (o_words_done),
        .o_err        (o_err)
    );

    logic [ENT_W-1:0]  exp_q[$];
    logic [ENT_W-1:0]  obs_q[$];
    int                wre_cnt = 0;
    int                n_cmp = 0;
    int                n_err = 0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [7:0]        csum = '0;

    // Write monitor
    always @(negedge clk) begin
        if (rst_n && o_mem_wre) begin
            obs_q.push_back({o_mem_ad, o_mem_din});
            wre_cnt++;
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input string tag);
        logic rdy;
        int   n;
        i_s_valid = 1'b1;
        i_s_data  = b;
        n = 0;
        do begin
            rdy = o_s_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 100);
        i_s_valid = 1'b0;
        if (!rdy) chk({tag, " accept timeout"}, 32'(rdy), 32'd1);
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w, input bit gap);
        for (int k = 0; k < int'(BPW); k++) begin
            csum = 8'(csum + w[8*k +: 8]);
            send_byte(w[8*k +: 8], "byte");
            if (gap) begin
                @(posedge clk);
                #1;
            end
        end
        exp_q.push_back({exp_addr, w});
        exp_addr = ADDR_W'(exp_addr + 1'b1);
    endtask

    task automatic begin_image();
        exp_addr = '0;
        csum     = '0;
    endtask

    task automatic send_csum();
`ifdef CHECKSUM_EN
        send_byte(8'(8'h00 - csum), "csum");
`endif
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (o_boot_mode !== 1'b0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " boot_mode"}, 32'(o_boot_mode), 32'd0);
    endtask

    task automatic compare_writes(input string tag);
        chk({tag, " write count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            chk({tag, " write"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " s_ready"},    32'(o_s_ready),    32'd0);
        chk({tag, " mem_ce"},     32'(o_mem_ce),     32'd1);
        chk({tag, " mem_wre"},    32'(o_mem_wre),    32'd0);
        chk({tag, " mem_ad"},     32'(o_mem_ad),     32'd0);
        chk({tag, " mem_din"},    32'(o_mem_din),    32'd0);
        chk({tag, " boot_mode"},  32'(o_boot_mode),  32'd1);
        chk({tag, " words_done"}, 32'(o_words_done), 32'd0);
        chk({tag, " err"},        32'(o_err),        32'd0);
    endtask

    initial begin
        int n0;

        // Power-on reset
        i_prog_len = 12'd3;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst_n = 1'b1;
        chk("por release s_ready", 32'(o_s_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("recv s_ready", 32'(o_s_ready), 32'd1);
        chk("recv boot_mode", 32'(o_boot_mode), 32'd1);

        // Basic 3-word image, write latency and boot_mode release
        begin_image();
        send_word(16'hA100, 1'b0);
        send_word(16'h7800, 1'b0);
        send_word(16'h0008, 1'b0);
        chk("t1 last wre", 32'(o_mem_wre), 32'd1);
        chk("t1 last ad", 32'(o_mem_ad), 32'd2);
        chk("t1 last din", 32'(o_mem_din), 32'h0008);
        chk("t1 boot during write", 32'(o_boot_mode), 32'd1);
`ifdef CHECKSUM_EN
        send_csum();
`else
        @(posedge clk);
        #1;
`endif
        chk("t1 boot_mode", 32'(o_boot_mode), 32'd0);
        chk("t1 wre", 32'(o_mem_wre), 32'd0);
        chk("t1 words_done", 32'(o_words_done), 32'd3);
        chk("t1 err", 32'(o_err), 32'd0);
        compare_writes("t1");

        // PC pass-through when done
        i_cpu_addr = 11'h005;
        #1;
        chk("t4 mem_ad pc", 32'(o_mem_ad), 32'h005);
        chk("t4 wre", 32'(o_mem_wre), 32'd0);
        chk("t4 ce", 32'(o_mem_ce), 32'd1);
        i_cpu_addr = 11'h7FF;
        #1;
        chk("t4 mem_ad pc2", 32'(o_mem_ad), 32'h7FF);

        // Reload with start, stream with 1-0-1 valid gaps, 2 words
        i_prog_len = 12'd2;
        pulse_start();
        chk("t4 start boot_mode", 32'(o_boot_mode), 32'd1);
        chk("t4 start words_done", 32'(o_words_done), 32'd0);
        begin_image();
        n0 = wre_cnt;
        send_word(16'h1234, 1'b1);
        send_word(16'hBEEF, 1'b1);
        send_csum();
        wait_done("t3");
        chk("t3 wre cycles", 32'(wre_cnt - n0), 32'd2);
        chk("t3 words_done", 32'(o_words_done), 32'd2);
        compare_writes("t3");

        // Async reset after one of three words, then full reload
        i_prog_len = 12'd3;
        pulse_start();
        begin_image();
        send_word(16'h1111, 1'b0);
        @(posedge clk);
        #1;
        send_byte(8'h22, "partial");
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t5 rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        begin_image();
        send_word(16'hC0DE, 1'b0);
        send_word(16'h5A5A, 1'b0);
        send_word(16'h0102, 1'b0);
        send_csum();
        wait_done("t5");
        chk("t5 words_done", 32'(o_words_done), 32'd3);
        compare_writes("t5");

        // prog_len == 0 straight to done, no bytes consumed
        i_prog_len = 12'd0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("t2 cycle1 boot_mode", 32'(o_boot_mode), 32'd1);
        chk("t2 cycle1 s_ready", 32'(o_s_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("t2 cycle2 boot_mode", 32'(o_boot_mode), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("t2 s_ready", 32'(o_s_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        chk("t2 words_done", 32'(o_words_done), 32'd0);
        compare_writes("t2");

        // Full-size image: last write at 2**ADDR_W-1, no wrap to 0
        i_prog_len = 12'd2048;
        pulse_start();
        begin_image();
        for (int i = 0; i < 2048; i++) begin
            send_word(DATA_W'(i * 40503 + 7), 1'b0);
        end
        send_csum();
        wait_done("full");
        chk("full words_done", 32'(o_words_done), 32'd2048);
        compare_writes("full");

`ifdef CHECKSUM_EN
        // Good checksum
        i_prog_len = 12'd1;
        pulse_start();
        begin_image();
        send_word(16'h0201, 1'b0);
        send_byte(8'hFD, "csum good");
        chk("t6 good boot_mode", 32'(o_boot_mode), 32'd0);
        chk("t6 good err", 32'(o_err), 32'd0);
        chk("t6 good s_ready", 32'(o_s_ready), 32'd0);
        compare_writes("t6 good");

        // Bad checksum parks in error
        pulse_start();
        begin_image();
        send_word(16'h0201, 1'b0);
        send_byte(8'hFE, "csum bad");
        chk("t6 bad err", 32'(o_err), 32'd1);
        chk("t6 bad boot_mode", 32'(o_boot_mode), 32'd1);
        chk("t6 bad s_ready", 32'(o_s_ready), 32'd0);
        chk("t6 bad wre", 32'(o_mem_wre), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("t6 err held", 32'(o_err), 32'd1);
        compare_writes("t6 bad");

        // Recovery from error with start
        pulse_start();
        chk("t6 recover err", 32'(o_err), 32'd0);
        chk("t6 recover boot_mode", 32'(o_boot_mode), 32'd1);
        begin_image();
        send_word(16'h0201, 1'b0);
        send_csum();
        chk("t6 recover done", 32'(o_boot_mode), 32'd0);
        compare_writes("t6 recover");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
